ram_seq_ctrl: RTL and testbench
===============================

RAM_SEQ_CTRL -- requirements
Module: ram_seq_ctrl

Interface
REQ-001 Parameters (one per line: name, default, meaning) SHALL be:
  - AW, 5, RAM address width.
  - DW, 4, RAM data width.
  - TICK_MAX, 50000000, CLOCK_50 cycles per scan step.
  - DB_CYCLES, 1000000, cycles a raw button must hold a new level before it is accepted.
REQ-002 Ports (one per line: name  direction  width  meaning) SHALL be:
  - CLOCK_50  in  1  sole clock, rising edge.
  - rst_n  in  1  asynchronous active-low reset.
  - mode_sw  in  1  raw switch, 1=edit, 0=scan.
  - key_wr_n  in  1  raw push button, active-low: write.
  - key_ld_n  in  1  raw push button, active-low: load pointer.
  - sw_addr  in  AW  pointer load value.
  - sw_data  in  DW  write data.
  - ram_addr  out  AW  address to RAM.
  - ram_data  out  DW  write data to RAM.
  - ram_wren  out  1  RAM write enable.
  - tick  out  1  one-cycle pulse per scan step.
  - edit_led  out  1  high while in edit or write states.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low (rst_n); all flops SHALL be clocked by CLOCK_50 only.

Function
REQ-004 mode_sw, key_wr_n and key_ld_n SHALL each pass through a 2-flop synchronizer before any use.
REQ-005 Each button SHALL have a debouncer: a counter restarts whenever the synchronized level equals the debounced level; the debounced level flips after DB_CYCLES consecutive cycles of disagreement.
REQ-006 A debounced 1->0 transition SHALL generate exactly one press pulse lasting one cycle; releases generate nothing; a held button yields one pulse only.
REQ-007 States SHALL be SCAN, EDIT, WR, INC; ram_addr SHALL always equal the internal pointer ptr.
REQ-008 SCAN: tick counter counts 0..TICK_MAX-1; at TICK_MAX-1 it wraps to 0, tick=1 for that cycle, ptr increments (31 wraps to 0); button presses ignored.
REQ-009 SCAN -> EDIT when the synchronized mode_sw=1; the tick counter clears to 0 and holds in all non-SCAN states; ptr is preserved.
REQ-010 EDIT -> SCAN when the synchronized mode_sw=0; ptr preserved; the first tick occurs TICK_MAX cycles later.
REQ-011 EDIT, load pulse: ptr <= sw_addr next cycle, state stays EDIT.
REQ-012 EDIT, write pulse (no load pulse): ram_data <= sw_data and state -> WR on the same edge.
REQ-013 Load and write pulses in the same cycle: load wins; the write is discarded.
REQ-014 WR: ram_wren=1 for exactly one cycle with ram_addr=ptr and ram_data stable; then -> INC.
REQ-015 INC: ptr <= ptr+1 mod 2^AW; then -> EDIT, or -> SCAN if mode_sw=0.
REQ-016 Write latency: pulse in cycle N, ram_wren high in cycle N+1, incremented ptr visible in cycle N+2.
REQ-017 mode_sw change during WR/INC SHALL NOT abort the sequence; it is honoured after INC.
REQ-018 ram_wren SHALL never be high in SCAN or EDIT, nor for two consecutive cycles.
REQ-019 edit_led SHALL be 1 in EDIT, WR and INC, and 0 in SCAN.

Reset
REQ-020 On rst_n=0 (asynchronous): state=SCAN, ptr=0, ram_data=0, ram_wren=0, tick=0, tick counter=0, debounce counters=0, synchronizer and debounced levels=1 (released), mode synchronizer=0.
REQ-021 Reset asserted mid-write SHALL force ram_wren=0 immediately; no increment occurs.
REQ-022 After rst_n deassertion with mode_sw=1, EDIT SHALL be entered after the synchronizer latency (3rd edge).

Verification (TICK_MAX=4, DB_CYCLES=3)
REQ-023 Scan: mode_sw=0 from reset -> tick every 4 cycles, ram_addr 0,1,2...; 31 wraps to 0; ram_wren never high.
REQ-024 Write: mode_sw=1, sw_data=0xA, ptr=5, key_wr_n held low 10 cycles -> one ram_wren pulse at addr 5 with data 0xA, then ptr=6.
REQ-025 Bounce: key_wr_n toggling with runs of 1-2 cycles -> no press pulse, no ram_wren.
REQ-026 Load and write: presses confirmed in the same cycle with sw_addr=17 -> ptr=17, no ram_wren.
REQ-027 Wrap and mode change: ptr=31, write press, mode_sw->0 during WR -> write at 31, ptr=0, state SCAN, first tick 4 cycles later.
REQ-028 Reset: rst_n low during the ram_wren cycle -> ram_wren=0 immediately; all outputs at reset values.

Source files
------------

// File: rtl/ram_seq_ctrl.sv
// ram_seq_ctrl
//   Front-panel controller for a small RAM. In scan mode the address pointer
//   steps through the RAM once every TICK_MAX clocks. In edit mode two
//   debounced push buttons either load the pointer from the switches or write
//   sw_data at the pointer and then advance it.
//
// Ports
//   CLOCK_50  in   1   sole clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   mode_sw   in   1   raw switch: 1 = edit, 0 = scan
//   key_wr_n  in   1   raw push button, active-low: write
//   key_ld_n  in   1   raw push button, active-low: load pointer
//   sw_addr   in   AW  pointer load value
//   sw_data   in   DW  write data
//   ram_addr  out  AW  address to RAM (always the internal pointer)
//   ram_data  out  DW  write data to RAM
//   ram_wren  out  1   RAM write enable, one cycle per write
//   tick      out  1   one-cycle pulse per scan step
//   edit_led  out  1   high while editing or writing
module ram_seq_ctrl #(
    parameter int AW        = 5,
    parameter int DW        = 4,
    parameter int TICK_MAX  = 50000000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic          CLOCK_50,
    input  logic          rst_n,
    input  logic          mode_sw,
    input  logic          key_wr_n,
    input  logic          key_ld_n,
    input  logic [AW-1:0] sw_addr,
    input  logic [DW-1:0] sw_data,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_wren,
    output logic          tick,
    output logic          edit_led
);

    localparam int TW = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_MAX - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_SCAN = 2'd0,
        S_EDIT = 2'd1,
        S_WR   = 2'd2,
        S_INC  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Mode switch synchronizer (resets to scan)
    // ------------------------------------------------------------------
    logic mode_s1_reg;
    logic mode_s2_reg;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            mode_s1_reg <= 1'b0;
            mode_s2_reg <= 1'b0;
        end else begin
            mode_s1_reg <= mode_sw;
            mode_s2_reg <= mode_s1_reg;
        end
    end

    // ------------------------------------------------------------------
    // Button synchronizers, debouncers and press detectors.
    // Index 0 = write button, index 1 = load button.
    // ------------------------------------------------------------------
    logic [1:0] key_raw;
    logic [1:0] press;

    assign key_raw = {key_ld_n, key_wr_n};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic          s1_reg;
            logic          s2_reg;
            logic          level_reg;
            logic          level_d_reg;
            logic [CW-1:0] cnt_reg;

            always_ff @(posedge CLOCK_50 or negedge rst_n) begin
                if (!rst_n) begin
                    s1_reg      <= 1'b1;
                    s2_reg      <= 1'b1;
                    level_reg   <= 1'b1;
                    level_d_reg <= 1'b1;
                    cnt_reg     <= '0;
                end else begin
                    s1_reg      <= key_raw[gi];
                    s2_reg      <= s1_reg;
                    level_d_reg <= level_reg;
                    // cnt_reg holds the number of consecutive disagreeing
                    // cycles seen so far; the DB_CYCLES-th one flips the level.
                    if (s2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        level_reg <= s2_reg;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
            end

            // Falling edge of the debounced level: one pulse per press.
            assign press[gi] = level_d_reg & ~level_reg;
        end
    endgenerate

    logic press_wr;
    logic press_ld;

    assign press_wr = press[0];
    assign press_ld = press[1];

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t        state_reg,    state_next;
    logic [AW-1:0] ptr_reg,      ptr_next;
    logic [TW-1:0] tick_cnt_reg, tick_cnt_next;
    logic [DW-1:0] data_reg,     data_next;
    logic          tick_next;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_SCAN;
            ptr_reg      <= '0;
            tick_cnt_reg <= '0;
            data_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            tick_cnt_reg <= tick_cnt_next;
            data_reg     <= data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        tick_cnt_next = '0;
        data_next     = data_reg;
        tick_next     = 1'b0;

        case (state_reg)
            S_SCAN: begin
                if (mode_s2_reg) begin
                    // Leaving scan takes priority over a pending step.
                    state_next = S_EDIT;
                end else if (tick_cnt_reg == TICK_LAST) begin
                    tick_next = 1'b1;
                    ptr_next  = ptr_reg + AW'(1);
                end else begin
                    tick_cnt_next = tick_cnt_reg + TW'(1);
                end
            end

            S_EDIT: begin
                if (!mode_s2_reg) begin
                    state_next = S_SCAN;
                end else if (press_ld) begin
                    // A simultaneous write press is dropped here.
                    ptr_next = sw_addr;
                end else if (press_wr) begin
                    data_next  = sw_data;
                    state_next = S_WR;
                end
            end

            S_WR: begin
                // The pointer advances as WR is left so the incremented
                // address is already visible during INC.
                ptr_next   = ptr_reg + AW'(1);
                state_next = S_INC;
            end

            S_INC: begin
                state_next = mode_s2_reg ? S_EDIT : S_SCAN;
            end

            default: begin
                state_next = S_SCAN;
            end
        endcase
    end

    // Decoded straight from the state register so that an asynchronous
    // reset drops the write enable immediately.
    assign ram_wren = (state_reg == S_WR);
    assign edit_led = (state_reg != S_SCAN);
    assign ram_addr = ptr_reg;
    assign ram_data = data_reg;
    assign tick     = tick_next;

endmodule

// File: tb/tb_ram_seq_ctrl.sv
module tb_ram_seq_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n    = 1'b0;
    logic       mode_sw  = 1'b0;
    logic       key_wr_n = 1'b1;
    logic       key_ld_n = 1'b1;
    logic [4:0] sw_addr  = 5'd0;
    logic [3:0] sw_data  = 4'd0;
    logic [4:0] ram_addr;
    logic [3:0] ram_data;
    logic       ram_wren;
    logic       tick;
    logic       edit_led;

    int checks   = 0;
    int failures = 0;

    ram_seq_ctrl #(
        .AW       (5),
        .DW       (4),
        .TICK_MAX (4),
        .DB_CYCLES(3)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .rst_n   (rst_n),
        .mode_sw (mode_sw),
        .key_wr_n(key_wr_n),
        .key_ld_n(key_ld_n),
        .sw_addr (sw_addr),
        .sw_data (sw_data),
        .ram_addr(ram_addr),
        .ram_data(ram_data),
        .ram_wren(ram_wren),
        .tick    (tick),
        .edit_led(edit_led)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic       mode;
        logic       wr_n;
        logic       ld_n;
        logic [4:0] sa;
        logic [3:0] sd;
        logic [4:0] ea;
        logic [3:0] ed;
        logic       ew;
        logic       et;
        logic       el;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic mode, input logic wr_n, input logic ld_n,
                       input logic [4:0] sa, input logic [3:0] sd,
                       input logic [4:0] ea, input logic [3:0] ed,
                       input logic ew, input logic et, input logic el);
        vec_t v;
        v.mode = mode; v.wr_n = wr_n; v.ld_n = ld_n; v.sa = sa; v.sd = sd;
        v.ea = ea; v.ed = ed; v.ew = ew; v.et = et; v.el = el;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, 32'(ram_addr), 32'd0);
        check({tag, "_data"}, 32'(ram_data), 32'd0);
        check({tag, "_wren"}, 32'(ram_wren), 32'd0);
        check({tag, "_tick"}, 32'(tick),     32'd0);
        check({tag, "_led"},  32'(edit_led), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bp[14] = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1};
        bit seen;

        // ---------------- stimulus table (starts in EDIT, ptr=0, data=0) ----
        // load pointer 5
        add(5, 1, 1, 0, 5, 0,   0, 0,   0, 0, 1);
        add(1, 1, 1, 0, 5, 0,   5, 0,   0, 0, 1);
        add(6, 1, 1, 1, 5, 0,   5, 0,   0, 0, 1);
        // write 0xA at 5, button held 10 cycles
        add(5, 1, 0, 1, 5, 4'hA, 5, 0,    0, 0, 1);
        add(1, 1, 0, 1, 5, 4'hA, 5, 4'hA, 1, 0, 1);
        add(4, 1, 0, 1, 5, 4'hA, 6, 4'hA, 0, 0, 1);
        add(6, 1, 1, 1, 5, 4'hA, 6, 4'hA, 0, 0, 1);
        // bouncing write button: no effect
        foreach (bp[i]) add(1, 1, bp[i][0], 1, 5, 4'h3, 6, 4'hA, 0, 0, 1);
        add(5, 1, 1, 1, 5, 4'h3, 6, 4'hA, 0, 0, 1);
        // load and write pressed together: load 17, no write
        add(5, 1, 0, 0, 17, 4'h3, 6,  4'hA, 0, 0, 1);
        add(3, 1, 0, 0, 17, 4'h3, 17, 4'hA, 0, 0, 1);
        add(6, 1, 1, 1, 17, 4'h3, 17, 4'hA, 0, 0, 1);
        // load pointer 31
        add(5, 1, 1, 0, 31, 4'h3, 17, 4'hA, 0, 0, 1);
        add(1, 1, 1, 0, 31, 4'h3, 31, 4'hA, 0, 0, 1);
        add(6, 1, 1, 1, 31, 4'h3, 31, 4'hA, 0, 0, 1);
        // write 0x5 at 31, mode drops during WR: wrap to 0, back to scan
        add(5, 1, 0, 1, 31, 4'h5, 31, 4'hA, 0, 0, 1);
        add(1, 0, 0, 1, 31, 4'h5, 31, 4'h5, 1, 0, 1);
        add(1, 0, 1, 1, 31, 4'h5, 0,  4'h5, 0, 0, 1);
        add(3, 0, 1, 1, 31, 4'h5, 0,  4'h5, 0, 0, 0);
        add(1, 0, 1, 1, 31, 4'h5, 0,  4'h5, 0, 1, 0);
        add(3, 0, 1, 1, 31, 4'h5, 1,  4'h5, 0, 0, 0);
        add(1, 0, 1, 1, 31, 4'h5, 1,  4'h5, 0, 1, 0);
        add(1, 0, 1, 1, 31, 4'h5, 2,  4'h5, 0, 0, 0);

        // ---------------- reset values, then scan from reset ----------------
        repeat (3) @(negedge CLOCK_50);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        for (int c = 1; c <= 132; c++) begin
            @(negedge CLOCK_50);
            check("scan_tick", 32'(tick),     32'((c % 4) == 3));
            check("scan_addr", 32'(ram_addr), 32'((c / 4) % 32));
            check("scan_wren", 32'(ram_wren), 32'd0);
            check("scan_led",  32'(edit_led), 32'd0);
            $display("scan cycle %0d addr=%0d tick=%0b", c, ram_addr, tick);
        end

        // ---------------- reset with mode_sw=1: EDIT on 3rd edge ------------
        rst_n   = 1'b0;
        mode_sw = 1'b1;
        #1;
        check_reset_outputs("reset2");
        repeat (2) @(negedge CLOCK_50);
        rst_n = 1'b1;
        @(negedge CLOCK_50);
        check("entry_led_e1", 32'(edit_led), 32'd0);
        @(negedge CLOCK_50);
        check("entry_led_e2", 32'(edit_led), 32'd0);
        @(negedge CLOCK_50);
        check("entry_led_e3", 32'(edit_led), 32'd1);
        check("entry_addr",   32'(ram_addr), 32'd0);

        // ---------------- table-driven sequence -----------------------------
        for (int i = 0; i < vecs.size(); i++) begin
            mode_sw  = vecs[i].mode;
            key_wr_n = vecs[i].wr_n;
            key_ld_n = vecs[i].ld_n;
            sw_addr  = vecs[i].sa;
            sw_data  = vecs[i].sd;
            @(negedge CLOCK_50);
            check("row_addr", 32'(ram_addr), 32'(vecs[i].ea));
            check("row_data", 32'(ram_data), 32'(vecs[i].ed));
            check("row_wren", 32'(ram_wren), 32'(vecs[i].ew));
            check("row_tick", 32'(tick),     32'(vecs[i].et));
            check("row_led",  32'(edit_led), 32'(vecs[i].el));
            $display("row %0d addr=%0d data=%0h wren=%0b tick=%0b led=%0b",
                     i, ram_addr, ram_data, ram_wren, tick, edit_led);
        end

        // ---------------- reset during the write cycle ----------------------
        mode_sw  = 1'b1;
        key_wr_n = 1'b1;
        key_ld_n = 1'b1;
        sw_data  = 4'h9;
        repeat (3) @(negedge CLOCK_50);
        check("rstwr_led_edit", 32'(edit_led), 32'd1);
        key_wr_n = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge CLOCK_50);
            if (ram_wren) seen = 1'b1;
        end
        check("rstwr_wren_seen", 32'(seen), 32'd1);
        check("rstwr_data_before", 32'(ram_data), 32'h9);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rstwr");
        $display("reset during write addr=%0d data=%0h wren=%0b", ram_addr, ram_data, ram_wren);
        repeat (2) @(negedge CLOCK_50);
        check_reset_outputs("rstwr_hold");
        rst_n    = 1'b1;
        mode_sw  = 1'b0;
        key_wr_n = 1'b1;
        @(negedge CLOCK_50);
        check("rstwr_after_addr", 32'(ram_addr), 32'd0);
        check("rstwr_after_wren", 32'(ram_wren), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
